// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start bit, MSB-first data, optional even parity, stop bits.
// Samples mid-bit from an internal baud counter and flags break, parity and frame errors.
module uart_rx_deframer #(
    parameter int unsigned SYSCLK_RATE = 100000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_BIT  = 1,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Data_Out,
    output logic                 Data_Rdy,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy
);

    localparam int unsigned ClksPerBit = SYSCLK_RATE / BAUD_RATE;
    localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
    localparam int unsigned BitW       = $clog2(DATA_BITS + STOP_BITS + 1);

    localparam logic [CntW-1:0] HalfBit  = CntW'(ClksPerBit / 2);
    localparam logic [CntW-1:0] FullBit  = CntW'(ClksPerBit);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rs_q, rs_prev_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 zero_q, zero_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           err_q, err_d;
    logic                 rdy_q, rdy_d;
    logic                 busy_q, busy_d;
    logic                 tick;

    assign tick     = (cnt_q == CntW'(1));
    assign Data_Out = data_q;
    assign Data_Rdy = rdy_q;
    assign Rx_Error = err_q;
    assign Rx_Busy  = busy_q;

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            zero_q    <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= Rx;
            rs_q      <= rx_meta_q;
            rs_prev_q <= rs_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            zero_q    <= zero_d;
            data_q    <= data_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        zero_d    = zero_q;
        data_d    = data_q;
        err_d     = err_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;

        if (state_q inside {StStart, StData, StParity, StStop}) begin
            cnt_d = tick ? FullBit : cnt_q - CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (rs_prev_q && !rs_q) begin
                    cnt_d   = HalfBit;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (rs_q) begin
                        state_d = StIdle;
                    end else begin
                        busy_d    = 1'b1;
                        err_d     = '0;
                        zero_d    = 1'b1;
                        bit_d     = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        state_d   = StData;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = {shift_q[DATA_BITS-2:0], rs_q};
                    zero_d  = zero_q & ~rs_q;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY_BIT != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    par_err_d = rs_q ^ (^shift_q);
                    zero_d    = zero_q & ~rs_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (tick) begin
                    frm_err_d = frm_err_q | ~rs_q;
                    zero_d    = zero_q & ~rs_q;
                    if (bit_q == LastStop) begin
                        // Outputs update on this edge so a new start edge is seen next cycle.
                        rdy_d = 1'b1;
                        bit_d = '0;
                        if (zero_q && !rs_q) begin
                            err_d  = 3'b001;
                            data_d = '0;
                        end else begin
                            err_d  = {frm_err_q | ~rs_q, par_err_q, 1'b0};
                            data_d = shift_q;
                        end
                        busy_d  = ~rs_q;
                        state_d = rs_q ? StIdle : StWaitIdle;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StWaitIdle: begin
                if (rs_q) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer at 16 clocks per bit.
// Stimulus pushes expected frames; a negedge monitor checks every Data_Rdy pulse.
module tb_uart_rx_deframer;

    logic       SysClk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx = 1'b1;
    logic [7:0] Data_Out;
    logic       Data_Rdy;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] err;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    uart_rx_deframer #(
        .SYSCLK_RATE(16),
        .BAUD_RATE  (1),
        .DATA_BITS  (8),
        .PARITY_BIT (1),
        .STOP_BITS  (2)
    ) dut (
        .SysClk  (SysClk),
        .Rst     (Rst),
        .Rx      (Rx),
        .Data_Out(Data_Out),
        .Data_Rdy(Data_Rdy),
        .Rx_Error(Rx_Error),
        .Rx_Busy (Rx_Busy)
    );

    always #5 SysClk = ~SysClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every Data_Rdy cycle must match the oldest expected frame.
    always @(negedge SysClk) begin
        if (Data_Rdy === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rdy: got Data_Out=%0h Rx_Error=%0b expected no pulse",
                         Data_Out, Rx_Error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdy_data", 32'(Data_Out), 32'(e.data));
                check("rdy_error", 32'(Rx_Error), 32'(e.err));
                check("rdy_busy", 32'(Rx_Busy), 32'(e.busy));
            end
        end
    end

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (16) @(negedge SysClk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s0, input logic s1);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        send_bit(s0);
        send_bit(s1);
    endtask

    task automatic idle(input int bits);
        Rx = 1'b1;
        repeat (bits * 16) @(negedge SysClk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic busy_seen;
        repeat (4) @(negedge SysClk);
        Rst = 1'b0;
        @(negedge SysClk);
        check("reset_data", 32'(Data_Out), 32'h0);
        check("reset_rdy", 32'(Data_Rdy), 32'h0);
        check("reset_error", 32'(Rx_Error), 32'h0);
        check("reset_busy", 32'(Rx_Busy), 32'h0);
        idle(2);

        // 1: good frame
        sb.push_back('{data: 8'hA5, err: 3'b000, busy: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("good_pending", 32'(sb.size()), 32'd0);

        // 2: parity error, held two bit-times later
        sb.push_back('{data: 8'hAA, err: 3'b010, busy: 1'b0});
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1);
        idle(2);
        check("parity_held_error", 32'(Rx_Error), 32'b010);
        check("parity_held_data", 32'(Data_Out), 32'hAA);
        check("parity_pending", 32'(sb.size()), 32'd0);

        // 3: frame error then line held low
        sb.push_back('{data: 8'hAA, err: 3'b100, busy: 1'b1});
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (30 * 16) @(negedge SysClk);
        check("frame_busy_low", 32'(Rx_Busy), 32'h1);
        check("frame_error_held", 32'(Rx_Error), 32'b100);
        Rx = 1'b1;
        repeat (5) @(negedge SysClk);
        check("frame_busy_release", 32'(Rx_Busy), 32'h0);
        idle(2);
        check("frame_pending", 32'(sb.size()), 32'd0);

        // 4: break, then good frame clears the error
        sb.push_back('{data: 8'h00, err: 3'b001, busy: 1'b1});
        Rx = 1'b0;
        repeat (12 * 16) @(negedge SysClk);
        Rx = 1'b1;
        repeat (8) @(negedge SysClk);
        check("break_busy_release", 32'(Rx_Busy), 32'h0);
        idle(2);
        sb.push_back('{data: 8'h3C, err: 3'b000, busy: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("break_pending", 32'(sb.size()), 32'd0);

        // 5: short glitch is rejected
        Rx = 1'b0;
        busy_seen = 1'b0;
        repeat (5) @(negedge SysClk);
        Rx = 1'b1;
        repeat (40) begin
            @(negedge SysClk);
            busy_seen = busy_seen | Rx_Busy;
        end
        check("glitch_busy", 32'(busy_seen), 32'h0);
        sb.push_back('{data: 8'h81, err: 3'b000, busy: 1'b0});
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("glitch_pending", 32'(sb.size()), 32'd0);

        // 6: reset during data bit 4 of 8'hF0
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        Rx = 1'b0;
        repeat (8) @(negedge SysClk);
        Rst = 1'b1;
        Rx  = 1'b1;
        @(negedge SysClk);
        check("rst_data", 32'(Data_Out), 32'h0);
        check("rst_rdy", 32'(Data_Rdy), 32'h0);
        check("rst_error", 32'(Rx_Error), 32'h0);
        check("rst_busy", 32'(Rx_Busy), 32'h0);
        Rst = 1'b0;
        idle(4);
        sb.push_back('{data: 8'h5A, err: 3'b000, busy: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        idle(2);
        check("final_pending", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
